// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI flash read path (read engine and word buffer).
package spi_flash_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam logic [31:0] DIE_SIZE = 32'h0200_0000;

    typedef enum logic [7:0] {
        RD_SLOW     = 8'h03,
        RD_FAST     = 8'h0B,
        RD_DUAL_OUT = 8'h3B,
        RD_QUAD_OUT = 8'h6B
    } rd_mode_e;

    typedef struct packed {
        logic [2:0]        bytes;
        logic [WORD_W-1:0] data;
    } rd_word_t;

    // Bit offset of a byte lane; big-endian fills from the top lane down (3-lane == ~lane).
    function automatic logic [4:0] lane_shift(input logic [1:0] lane, input logic big_endian);
        return big_endian ? {~lane, 3'b000} : {lane, 3'b000};
    endfunction

endpackage

// File: rtl/spi_rd_sync_fifo.sv
// First-word-fall-through synchronous FIFO of packed read words with level and drop reporting.
module spi_rd_sync_fifo
    import spi_flash_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wr_en,
    input  rd_word_t                 wr_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output rd_word_t                 rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_next,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    rd_word_t      mem [DEPTH];
    logic [AW:0]   wr_cnt, rd_cnt;
    logic          empty, full, push, pop;

    // Counters carry one extra bit so full and empty stay distinguishable.
    assign level      = wr_cnt - rd_cnt;
    assign empty      = (level == '0);
    assign full       = level[AW];
    assign pop        = rd_en & ~empty;
    assign push       = wr_en & (~full | pop);
    assign drop       = wr_en & full & ~pop;
    assign level_next = level + (AW+1)'(push) - (AW+1)'(pop);

    assign rd_valid = ~empty;
    assign rd_data  = empty ? '0 : mem[rd_cnt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push) wr_cnt <= wr_cnt + 1'b1;
            if (pop)  rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_cnt[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/spi_rd_word_buffer.sv
// Packs the flash read byte stream into 32-bit words and buffers them for the consumer.
// Define SPI_RD_BUF_BIG_ENDIAN_EN to pack the first byte into bits [31:24].
module spi_rd_word_buffer
    import spi_flash_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                     system_clk,
    input  logic                     system_reset,
    input  logic                     soft_clear,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    input  logic                     byte_last,
    output logic                     fifo_full,
    output logic                     word_valid,
    output logic [WORD_W-1:0]        word_data,
    output logic [2:0]               word_bytes,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int LW = $clog2(DEPTH) + 1;
`ifdef SPI_RD_BUF_BIG_ENDIAN_EN
    localparam logic BIG_ENDIAN = 1'b1;
`else
    localparam logic BIG_ENDIAN = 1'b0;
`endif

    logic              srst;
    logic [1:0]        lane_cnt;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic              completes;
    logic              push_pend;
    rd_word_t          push_word;
    rd_word_t          head;
    logic [LW-1:0]     level_next;
    logic              drop;

    assign srst = system_reset | soft_clear;

    always_comb begin
        acc_next  = acc | (WORD_W'(byte_data) << lane_shift(lane_cnt, BIG_ENDIAN));
        completes = byte_valid & ((lane_cnt == 2'd3) | byte_last);
    end

    // Completed word is staged one cycle, so the packer keeps accepting bytes meanwhile.
    always_ff @(posedge system_clk) begin
        if (srst) begin
            lane_cnt  <= '0;
            acc       <= '0;
            push_pend <= 1'b0;
            push_word <= '0;
        end else begin
            push_pend <= completes;
            if (completes) begin
                push_word.data  <= acc_next;
                push_word.bytes <= {1'b0, lane_cnt} + 3'd1;
            end
            if (byte_valid) begin
                if (completes) begin
                    acc      <= '0;
                    lane_cnt <= '0;
                end else begin
                    acc      <= acc_next;
                    lane_cnt <= lane_cnt + 2'd1;
                end
            end
        end
    end

    spi_rd_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (system_clk),
        .srst       (srst),
        .wr_en      (push_pend),
        .wr_data    (push_word),
        .rd_en      (word_ready),
        .rd_valid   (word_valid),
        .rd_data    (head),
        .level      (level),
        .level_next (level_next),
        .drop       (drop)
    );

    assign word_data  = head.data;
    assign word_bytes = head.bytes;

    // Almost-full tracks the level the FIFO will hold after this edge.
    always_ff @(posedge system_clk) begin
        if (srst) begin
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            fifo_full <= (level_next >= LW'(DEPTH - AFULL_MARGIN));
            overflow  <= overflow | drop;
        end
    end

endmodule

// File: tb/tb_spi_rd_word_buffer.sv
// Directed self-checking bench for spi_rd_word_buffer (honours SPI_RD_BUF_BIG_ENDIAN_EN).
module tb_spi_rd_word_buffer;
    logic        system_clk = 1'b0;
    logic        system_reset, soft_clear, byte_valid, byte_last, word_ready;
    logic [7:0]  byte_data;
    logic        fifo_full, word_valid, overflow;
    logic [31:0] word_data;
    logic [2:0]  word_bytes;
    logic [4:0]  level;

    int npass = 0, ntotal = 0, nfail = 0;
    logic        cap_en = 1'b0, inv_en = 1'b0, saw_full = 1'b0, prev_full = 1'b0;
    int          inv_bad = 0, full_falls = 0, timeouts = 0;
    logic [34:0] cap_q[$];

`ifdef SPI_RD_BUF_BIG_ENDIAN_EN
    localparam logic [31:0] T1_W0 = 32'h1122_3344, T1_W1 = 32'h5566_0000;
    localparam logic [31:0] T4_LAST = 32'h1000_0000, T5_W = 32'hAABB_CCDD;
`else
    localparam logic [31:0] T1_W0 = 32'h4433_2211, T1_W1 = 32'h0000_6655;
    localparam logic [31:0] T4_LAST = 32'h0000_0010, T5_W = 32'hDDCC_BBAA;
`endif

    spi_rd_word_buffer #(.DEPTH(16), .AFULL_MARGIN(2)) dut (
        .system_clk   (system_clk),
        .system_reset (system_reset),
        .soft_clear   (soft_clear),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .fifo_full    (fifo_full),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .word_bytes   (word_bytes),
        .word_ready   (word_ready),
        .level        (level),
        .overflow     (overflow)
    );

    always #5 system_clk = ~system_clk;

    // Word made of bytes 4k..4k+3 in arrival order.
    function automatic logic [31:0] wk(input int k);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = 8'(4 * k + i);
`ifdef SPI_RD_BUF_BIG_ENDIAN_EN
        return {b[0], b[1], b[2], b[3]};
`else
        return {b[3], b[2], b[1], b[0]};
`endif
    endfunction

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic last);
        byte_valid = 1'b1; byte_data = d; byte_last = last;
        @(negedge system_clk);
        byte_valid = 1'b0; byte_last = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge system_clk);
    endtask

    task automatic pop1();
        word_ready = 1'b1;
        @(negedge system_clk);
        word_ready = 1'b0;
    endtask

    task automatic sclr();
        soft_clear = 1'b1;
        @(negedge system_clk);
        soft_clear = 1'b0;
    endtask

    task automatic fill_words(input int n);
        for (int w = 0; w < n; w++)
            for (int i = 0; i < 4; i++) put(8'(w * 4 + i), 1'b0);
    endtask

    always begin
        @(negedge system_clk);
        #1;
        if (cap_en && word_valid && word_ready) cap_q.push_back({word_bytes, word_data});
        if (inv_en) begin
            if (fifo_full !== (level >= 5'd14)) inv_bad++;
            if (fifo_full) saw_full = 1'b1;
            if (prev_full && !fifo_full) full_falls++;
            prev_full = fifo_full;
        end
    end

    initial begin
        system_reset = 1'b1; soft_clear = 1'b0; byte_valid = 1'b0;
        byte_data = 8'h00; byte_last = 1'b0; word_ready = 1'b0;
        tick(3);
        chk("rst_valid", 35'(word_valid), 35'(0));
        chk("rst_level", 35'(level), 35'(0));
        chk("rst_flags", 35'({fifo_full, overflow}), 35'(0));
        chk("rst_word",  35'({word_bytes, word_data}), 35'(0));
        system_reset = 1'b0;
        tick(1);

        // pop on empty is ignored
        pop1();
        chk("empty_pop_level", 35'(level), 35'(0));

        // Test 1: full word then 2-byte partial
        put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h44, 0);
        chk("t1_lat0", 35'(word_valid), 35'(0));
        put(8'h55, 0);
        chk("t1_lat1", 35'(word_valid), 35'(1));
        put(8'h66, 1);
        tick(2);
        chk("t1_level", 35'(level), 35'(2));
        chk("t1_w0", 35'({word_bytes, word_data}), {3'd4, T1_W0});
        pop1();
        chk("t1_w1", 35'({word_bytes, word_data}), {3'd2, T1_W1});
        pop1();
        chk("t1_drained", 35'({word_valid, level}), 35'(0));

        // Test 2: fill to 16 with no pops, then overflow
        sclr();
        for (int w = 0; w < 16; w++) begin
            for (int i = 0; i < 4; i++) put(8'(w * 4 + i), 1'b0);
            chk($sformatf("t2_level_%0d", w), 35'(level), 35'(w));
            chk($sformatf("t2_afull_%0d", w), 35'(fifo_full), 35'(w >= 14));
        end
        tick(1);
        chk("t2_level16", 35'(level), 35'(16));
        fill_words(1);
        chk("t2_ovf_pre", 35'(overflow), 35'(0));
        tick(1);
        chk("t2_ovf", 35'(overflow), 35'(1));
        chk("t2_level_hold", 35'(level), 35'(16));
        chk("t2_head", 35'(word_data), 35'(wk(0)));

        // Test 3: push and pop in the same cycle while full
        sclr();
        chk("t3_clr_ovf", 35'(overflow), 35'(0));
        fill_words(16);
        tick(1);
        for (int i = 0; i < 4; i++) put(8'(224 + i), 1'b0);
        word_ready = 1'b1;
        chk("t3_head_old", 35'(word_data), 35'(wk(0)));
        @(negedge system_clk);
        word_ready = 1'b0;
        chk("t3_level", 35'(level), 35'(16));
        chk("t3_ovf", 35'(overflow), 35'(0));
        chk("t3_head_next", 35'(word_data), 35'(wk(1)));
        repeat (14) pop1();
        chk("t3_w15", 35'(word_data), 35'(wk(15)));
        pop1();
        chk("t3_tail", 35'({word_bytes, word_data}), {3'd4, wk(56)});
        chk("t3_level1", 35'(level), 35'(1));

        // Test 4: 17-byte read with consumer always ready
        sclr();
        cap_q.delete();
        cap_en = 1'b1; word_ready = 1'b1;
        for (int b = 0; b < 17; b++) put(8'(b), b == 16);
        tick(4);
        cap_en = 1'b0; word_ready = 1'b0;
        chk("t4_count", 35'(cap_q.size()), 35'(5));
        for (int k = 0; k < 4 && k < cap_q.size(); k++)
            chk($sformatf("t4_w%0d", k), cap_q[k], {3'd4, wk(k)});
        if (cap_q.size() >= 5) chk("t4_last", cap_q[4], {3'd1, T4_LAST});

        // Test 5: soft_clear drops a partial word
        sclr();
        put(8'h01, 0); put(8'h02, 0);
        sclr();
        put(8'hAA, 0); put(8'hBB, 0); put(8'hCC, 0); put(8'hDD, 0);
        tick(1);
        chk("t5_level", 35'(level), 35'(1));
        chk("t5_word", 35'({word_bytes, word_data}), {3'd4, T5_W});

        // Test 6: back-pressured 128-byte stream with a consumer stall, pointers wrap
        sclr();
        cap_q.delete();
        cap_en = 1'b1; inv_en = 1'b1;
        fork
            begin
                for (int b = 0; b < 128; b++) begin
                    int guard = 0;
                    while (fifo_full && guard < 1000) begin
                        @(negedge system_clk);
                        guard++;
                    end
                    if (guard >= 1000) timeouts++;
                    put(8'(b), b == 127);
                end
            end
            begin
                word_ready = 1'b0; tick(70);
                word_ready = 1'b1; tick(10);
                word_ready = 1'b0; tick(20);
                word_ready = 1'b1;
            end
        join
        begin
            int g = 0;
            while (cap_q.size() < 32 && g < 500) begin
                @(negedge system_clk);
                g++;
            end
        end
        tick(2);
        cap_en = 1'b0; inv_en = 1'b0; word_ready = 1'b0;
        chk("t6_timeout", 35'(timeouts), 35'(0));
        chk("t6_count", 35'(cap_q.size()), 35'(32));
        for (int k = 0; k < 32 && k < cap_q.size(); k++)
            chk($sformatf("t6_w%0d", k), cap_q[k], {3'd4, wk(k)});
        chk("t6_afull_track", 35'(inv_bad), 35'(0));
        chk("t6_saw_full", 35'(saw_full), 35'(1));
        chk("t6_full_fell", 35'(full_falls > 0), 35'(1));
        chk("t6_ovf", 35'(overflow), 35'(0));
        chk("t6_level", 35'(level), 35'(0));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
